// File: rtl/and16_bist_pkg.sv
// rtl/and16_bist_pkg.sv - shared types and constants for the And16 sweep/check flow
package and16_bist_pkg;

  // Checker run state
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Expected-function selector codes
  localparam logic [1:0] OP_AND = 2'd0;
  localparam logic [1:0] OP_OR  = 2'd1;
  localparam logic [1:0] OP_XOR = 2'd2;

  localparam int unsigned DEFAULT_WIDTH     = 16;
  localparam logic [15:0] DEFAULT_MISR_POLY = 16'h1021;

endpackage

// File: rtl/misr_reg.sv
// rtl/misr_reg.sv - multiple-input signature register compacting one word per enabled cycle
// Ports: clk, rst_n (async active-low), clr (sync clear, wins over en),
//        en (absorb din this cycle), din (word to compact), sig (current signature)
module misr_reg #(
  parameter int unsigned      WIDTH = 16,
  parameter logic [WIDTH-1:0] POLY  = 16'h1021
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] sig
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sig <= '0;
    end else if (clr) begin
      sig <= '0;
    end else if (en) begin
      // Shift left, fold the ejected MSB back through the taps, then mix in the new word
      sig <= {sig[WIDTH-2:0], 1'b0} ^ (sig[WIDTH-1] ? POLY : '0) ^ din;
    end
  end

endmodule

// File: rtl/and16_response_checker.sv
// rtl/and16_response_checker.sv - checks (a, b, out) result beats against OP(a, b)
// Ports: clk, rst_n (async active-low); start (begin/clear a run);
//        in_valid/in_ready/in_a/in_b/in_out/in_last (result beat stream);
//        busy, done, pass (run status); vec_count, err_count (run counters);
//        fail_a/fail_b/fail_out (first mismatching beat); signature (MISR over in_out)
module and16_response_checker
  import and16_bist_pkg::*;
#(
  parameter int unsigned      WIDTH      = DEFAULT_WIDTH,
  parameter logic [1:0]       OP         = OP_AND,
  parameter logic [WIDTH-1:0] MISR_POLY  = DEFAULT_MISR_POLY,
  parameter logic [31:0]      EXPECT_CNT = 32'd0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [WIDTH-1:0] in_out,
  input  logic             in_last,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [31:0]      vec_count,
  output logic [15:0]      err_count,
  output logic [WIDTH-1:0] fail_a,
  output logic [WIDTH-1:0] fail_b,
  output logic [WIDTH-1:0] fail_out,
  output logic [WIDTH-1:0] signature
);

  state_t           state;
  logic             accept;
  logic             run_start;
  logic             mismatch;
  logic [WIDTH-1:0] expected;
  logic [31:0]      vec_next;
  logic [15:0]      err_next;

  // Ready is a pure decode of the state register, never of in_valid
  assign in_ready  = (state == ST_RUN);
  assign busy      = in_ready;
  assign accept    = in_valid & in_ready;
  // START only has effect outside RUN
  assign run_start = start & (state != ST_RUN);

  always_comb begin
    expected = in_a & in_b;
    case (OP)
      OP_OR:   expected = in_a | in_b;
      OP_XOR:  expected = in_a ^ in_b;
      default: expected = in_a & in_b;
    endcase
  end

  assign mismatch = (in_out != expected);
  assign vec_next = vec_count + 32'd1;
  assign err_next = (mismatch && (err_count != 16'hFFFF)) ? err_count + 16'd1 : err_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      done      <= 1'b0;
      pass      <= 1'b0;
      vec_count <= '0;
      err_count <= '0;
      fail_a    <= '0;
      fail_b    <= '0;
      fail_out  <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state     <= ST_RUN;
            done      <= 1'b0;
            pass      <= 1'b0;
            vec_count <= '0;
            err_count <= '0;
            fail_a    <= '0;
            fail_b    <= '0;
            fail_out  <= '0;
          end
        end
        ST_RUN: begin
          if (accept) begin
            vec_count <= vec_next;
            err_count <= err_next;
            // Only the first failure of the run is kept
            if (mismatch && (err_count == 16'd0)) begin
              fail_a   <= in_a;
              fail_b   <= in_b;
              fail_out <= in_out;
            end
            if (in_last) begin
              state <= ST_DONE;
              done  <= 1'b1;
              // Judged on the post-update counts so the LAST beat is included
              pass  <= (err_next == 16'd0) &&
                       ((EXPECT_CNT == 32'd0) || (vec_next == EXPECT_CNT));
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  misr_reg #(
    .WIDTH (WIDTH),
    .POLY  (MISR_POLY)
  ) u_misr (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (run_start),
    .en    (accept),
    .din   (in_out),
    .sig   (signature)
  );

endmodule

// File: tb/tb_and16_response_checker.sv
// tb/tb_and16_response_checker.sv - directed self-checking bench for and16_response_checker
module tb_and16_response_checker;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_a;
  logic [15:0] in_b;
  logic [15:0] in_out;
  logic        in_last;
  logic        busy;
  logic        done;
  logic        pass;
  logic [31:0] vec_count;
  logic [15:0] err_count;
  logic [15:0] fail_a;
  logic [15:0] fail_b;
  logic [15:0] fail_out;
  logic [15:0] signature;

  int errors = 0;
  int checks = 0;

  and16_response_checker #(
    .WIDTH      (16),
    .EXPECT_CNT (32'd4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_out    (in_out),
    .in_last   (in_last),
    .busy      (busy),
    .done      (done),
    .pass      (pass),
    .vec_count (vec_count),
    .err_count (err_count),
    .fail_a    (fail_a),
    .fail_b    (fail_b),
    .fail_out  (fail_out),
    .signature (signature)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Presents one beat for exactly one cycle; returns at the negedge after the accepting edge
  task automatic send_beat(input logic [15:0] a, input logic [15:0] b,
                           input logic [15:0] o, input logic last);
    @(negedge clk);
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    in_out   = o;
    in_last  = last;
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  initial begin
    rst_n    = 1'b0;
    start    = 1'b1;
    in_valid = 1'b1;
    in_a     = 16'hDEAD;
    in_b     = 16'hBEEF;
    in_out   = 16'h1234;
    in_last  = 1'b1;

    // 1 Reset with garbage inputs
    idle_cycles(2);
    check_eq("rst_ready", in_ready, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_pass", pass, 0);
    check_eq("rst_vec", vec_count, 0);
    check_eq("rst_err", err_count, 0);
    check_eq("rst_fail", {fail_a, fail_b}, 0);
    check_eq("rst_fail_out", fail_out, 0);
    check_eq("rst_sig", signature, 0);
    start    = 1'b0;
    rst_n    = 1'b1;
    // in_valid still high in IDLE: must be dropped
    idle_cycles(3);
    check_eq("idle_busy", busy, 0);
    check_eq("idle_vec", vec_count, 0);
    check_eq("idle_sig", signature, 0);
    in_valid = 1'b0;
    in_last  = 1'b0;

    // 2 Clean sweep
    pulse_start();
    check_eq("run_busy", busy, 1);
    check_eq("run_ready", in_ready, 1);
    send_beat(16'hFFFF, 16'h0000, 16'h0000, 1'b0);
    send_beat(16'hFFFF, 16'h0001, 16'h0001, 1'b0);
    send_beat(16'hFFFF, 16'h00FF, 16'h00FF, 1'b0);
    check_eq("clean_not_done", done, 0);
    send_beat(16'hFFFF, 16'hFFFF, 16'hFFFF, 1'b1);
    check_eq("clean_done", done, 1);
    check_eq("clean_busy", busy, 0);
    check_eq("clean_pass", pass, 1);
    check_eq("clean_vec", vec_count, 4);
    check_eq("clean_err", err_count, 0);
    check_eq("clean_sig", signature, 16'hFE05);
    check_eq("clean_fail", {fail_a, fail_b}, 0);

    // 3 Faults on beats 2 and 3
    pulse_start();
    check_eq("restart_vec", vec_count, 0);
    check_eq("restart_sig", signature, 0);
    check_eq("restart_done", done, 0);
    send_beat(16'hFFFF, 16'h0001, 16'h0001, 1'b0);
    send_beat(16'h0F0F, 16'hFF00, 16'h0F0F, 1'b0);
    send_beat(16'h00FF, 16'h00F0, 16'h0000, 1'b0);
    send_beat(16'h1234, 16'hFFFF, 16'h1234, 1'b1);
    check_eq("fault_done", done, 1);
    check_eq("fault_pass", pass, 0);
    check_eq("fault_vec", vec_count, 4);
    check_eq("fault_err", err_count, 2);
    check_eq("fault_fail_a", fail_a, 16'h0F0F);
    check_eq("fault_fail_b", fail_b, 16'hFF00);
    check_eq("fault_fail_out", fail_out, 16'h0F0F);

    // 4 Handshake: valid in DONE dropped, gaps, START mid-run ignored, mismatching LAST
    @(negedge clk);
    in_valid = 1'b1;
    in_out   = 16'hAAAA;
    idle_cycles(3);
    in_valid = 1'b0;
    check_eq("donevalid_vec", vec_count, 4);
    check_eq("donevalid_err", err_count, 2);
    check_eq("donevalid_done", done, 1);
    pulse_start();
    send_beat(16'h00FF, 16'h0F0F, 16'h000F, 1'b0);
    idle_cycles(2);
    check_eq("gap_vec", vec_count, 1);
    pulse_start();
    check_eq("midstart_vec", vec_count, 1);
    check_eq("midstart_busy", busy, 1);
    send_beat(16'h00FF, 16'h0F0F, 16'h000F, 1'b0);
    idle_cycles(1);
    send_beat(16'hF0F0, 16'hFFFF, 16'hF0F1, 1'b1);
    check_eq("hs_vec", vec_count, 3);
    check_eq("hs_err", err_count, 1);
    check_eq("hs_fail_out", fail_out, 16'hF0F1);
    check_eq("hs_done", done, 1);
    check_eq("hs_pass", pass, 0);

    // 5 Reset mid-run after 3 beats
    pulse_start();
    send_beat(16'h1111, 16'h2222, 16'h0000, 1'b0);
    send_beat(16'h3333, 16'h1111, 16'h1111, 1'b0);
    send_beat(16'hFFFF, 16'h5555, 16'hAAAA, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check_eq("midrst_vec", vec_count, 0);
    check_eq("midrst_err", err_count, 0);
    check_eq("midrst_ready", in_ready, 0);
    check_eq("midrst_sig", signature, 0);
    check_eq("midrst_fail_a", fail_a, 0);
    idle_cycles(1);
    rst_n = 1'b1;
    idle_cycles(1);
    check_eq("postrst_busy", busy, 0);
    pulse_start();
    send_beat(16'h0003, 16'h0006, 16'h0002, 1'b1);
    check_eq("postrst_vec", vec_count, 1);
    check_eq("postrst_done", done, 1);
    check_eq("postrst_pass", pass, 0);
    check_eq("postrst_sig", signature, 16'h0002);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
